// File: rtl/btn_cmd_if.sv
// Command channel between the button command stage and the 4-bit queue.
// The master issues single-cycle commands; the slave reports full/empty flags.
interface btn_cmd_if #(
    parameter int DW = 4
);
    logic          cmd_valid;
    logic          cmd_push;
    logic [DW-1:0] cmd_data;
    logic          full;
    logic          empty;

    modport master (
        output cmd_valid, cmd_push, cmd_data,
        input  full, empty
    );

    modport slave (
        input  cmd_valid, cmd_push, cmd_data,
        output full, empty
    );
endinterface

// File: rtl/btn_cmd_gen.sv
// Debounced push-button to single-cycle queue command generator.
// Optional BTN_CMD_AUTO_REPEAT_EN re-issues commands while the button is held.
module btn_cmd_gen #(
    parameter int DB_CYCLES     = 16,
    parameter int REPEAT_CYCLES = 64,
    parameter int DW            = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn,
    input  logic          enable,
    input  logic          push_pop,
    input  logic [DW-1:0] data_in,
    btn_cmd_if.master     q,
    output logic          reject,
    output logic [3:0]    reject_cnt
);
    localparam int MAXC = (DB_CYCLES > REPEAT_CYCLES) ? DB_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    sync;
    logic          btn_s;
    logic          issue;
    logic          rpt_hit;
    logic          fire;
    logic          blocked;

    assign btn_s = sync[1];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        issue   = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn_s) begin
                    state_n = DB_PRESS;
                    cnt_n   = '0;
                end
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    state_n = IDLE;
                end else if (cnt == DB_LAST) begin
                    issue   = 1'b1;
                    state_n = HELD;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_n = DB_RELEASE;
                    cnt_n   = '0;
                end
            end
            DB_RELEASE: begin
                if (btn_s) begin
                    state_n = HELD;
                end else if (cnt == DB_LAST) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef BTN_CMD_AUTO_REPEAT_EN
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYCLES - 1);

    logic [CW-1:0] rpt, rpt_n;

    // Repeat timer restarts on every entry to HELD and freezes while releasing.
    always_comb begin
        rpt_n   = rpt;
        rpt_hit = 1'b0;
        if (state == HELD && btn_s) begin
            if (rpt == RP_LAST) begin
                rpt_hit = 1'b1;
                rpt_n   = '0;
            end else begin
                rpt_n = rpt + 1'b1;
            end
        end
        if (state_n == HELD && state != HELD) begin
            rpt_n = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt <= '0;
        end else begin
            rpt <= rpt_n;
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    assign fire    = (issue | rpt_hit) & enable;
    assign blocked = push_pop ? q.full : q.empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync        <= '0;
            state       <= IDLE;
            cnt         <= '0;
            q.cmd_valid <= 1'b0;
            q.cmd_push  <= 1'b0;
            q.cmd_data  <= '0;
            reject      <= 1'b0;
            reject_cnt  <= '0;
        end else begin
            sync        <= {sync[0], btn};
            state       <= state_n;
            cnt         <= cnt_n;
            q.cmd_valid <= fire & ~blocked;
            reject      <= fire & blocked;
            if (fire && !blocked) begin
                q.cmd_push <= push_pop;
                if (push_pop) begin
                    q.cmd_data <= data_in;
                end
            end
            if (fire && blocked && reject_cnt != 4'd15) begin
                reject_cnt <= reject_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_btn_cmd_gen.sv
// Directed bench for btn_cmd_gen with an expected-command scoreboard.
// Define BTN_CMD_AUTO_REPEAT_EN to also exercise auto-repeat.
module tb_btn_cmd_gen;
    localparam int DB = 16;
    localparam int RP = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn = 1'b0;
    logic       enable = 1'b0;
    logic       push_pop = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic       reject;
    logic [3:0] reject_cnt;

    btn_cmd_if #(.DW(4)) qi ();

    btn_cmd_gen #(
        .DB_CYCLES    (DB),
        .REPEAT_CYCLES(RP),
        .DW           (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .enable    (enable),
        .push_pop  (push_pop),
        .data_in   (data_in),
        .q         (qi),
        .reject    (reject),
        .reject_cnt(reject_cnt)
    );

    typedef struct {
        bit         rej;
        bit         push;
        logic [3:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [3:0] last_data = 4'h0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference issue rule applied to the inputs currently driven.
    task automatic exp_issue(input int c);
        bit rej;
        if (!enable) return;
        rej = push_pop ? qi.full : qi.empty;
        if (!rej && push_pop) last_data = data_in;
        sb.push_back('{rej, push_pop, last_data, c});
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                e = sb.pop_front();
                chk("missing_cmd_cyc", cyc, e.cyc);
            end
            if (qi.cmd_valid === 1'b1 || reject === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {qi.cmd_valid, reject}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_cyc", cyc, e.cyc);
                    chk("out_reject", reject, e.rej);
                    chk("out_valid", qi.cmd_valid, !e.rej);
                    if (!e.rej) begin
                        chk("out_push", qi.cmd_push, e.push);
                        chk("out_data", qi.cmd_data, e.data);
                    end
                end
            end
        end
    endtask

    task automatic press(input int hold, input int gap);
        btn = 1'b1;
        exp_issue(cyc + DB + 3);
        step(hold);
        btn = 1'b0;
        step(gap);
    endtask

    initial begin
        qi.full  = 1'b0;
        qi.empty = 1'b1;
        step(3);
        chk("rst_valid", qi.cmd_valid, 0);
        chk("rst_push", qi.cmd_push, 0);
        chk("rst_data", qi.cmd_data, 0);
        chk("rst_reject", reject, 0);
        chk("rst_rcnt", reject_cnt, 0);
        reset = 1'b1;
        step(2);

        enable   = 1'b1;
        push_pop = 1'b1;
        data_in  = 4'hA;
        press(60, 40);
        chk("clean_data_hold", qi.cmd_data, 4'hA);

        data_in = 4'h5;
        for (int i = 0; i < 7; i++) begin
            btn = 1'b1;
            step(3);
            btn = 1'b0;
            step(3);
        end
        press(DB + 8, 2 * DB + 8);

        push_pop = 1'b0;
        data_in  = 4'hC;
        press(DB + 8, 2 * DB + 8);
        chk("rcnt_one", reject_cnt, 1);
        for (int i = 0; i < 16; i++) press(DB + 8, 2 * DB + 8);
        chk("rcnt_sat", reject_cnt, 15);

        qi.empty = 1'b0;
        press(DB + 8, 2 * DB + 8);
        chk("pop_data_hold", qi.cmd_data, 4'h5);

        push_pop = 1'b1;
        qi.full  = 1'b1;
        press(DB + 8, 2 * DB + 8);
        chk("rcnt_hold15", reject_cnt, 15);

        qi.full = 1'b0;
        enable  = 1'b0;
        btn     = 1'b1;
        step(100);
        chk("dis_state_held", dut.state, 2);
        btn = 1'b0;
        step(2 * DB + 8);
        chk("dis_rcnt", reject_cnt, 15);

        enable  = 1'b1;
        data_in = 4'h3;
        btn     = 1'b1;
        step(7);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", qi.cmd_valid, 0);
        chk("mid_rst_data", qi.cmd_data, 0);
        chk("mid_rst_rcnt", reject_cnt, 0);
        chk("mid_rst_state", dut.state, 0);
        last_data = 4'h0;
        step(3);
        chk("mid_rst_reject", reject, 0);
        reset = 1'b1;
        exp_issue(cyc + DB + 3);
        step(DB + 8);
        btn = 1'b0;
        step(2 * DB + 8);
        chk("post_rst_data", qi.cmd_data, 4'h3);

`ifdef BTN_CMD_AUTO_REPEAT_EN
        data_in = 4'h7;
        btn     = 1'b1;
        begin
            int c0;
            c0 = cyc + DB + 3;
            for (int k = 0; k < 4; k++) exp_issue(c0 + k * RP);
        end
        step(DB + 3 + 200);
        btn = 1'b0;
        step(300);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
